// File: rtl/branch_target_buffer_2bc.sv
// ============================================================================
// Module      : branch_target_buffer_2bc
// Description : Fully associative branch target buffer. Each entry holds a
//               valid bit, tag, target and a CTR_W-bit saturating direction
//               counter. Fetch lookup is combinational. Branches resolved in
//               EX update the buffer on the rising clock edge. Misses allocate
//               the lowest invalid entry, or the round-robin victim when the
//               buffer is full. A flush invalidates every entry.
//               Optional macro BTB_BYPASS_EN forwards a same-cycle EX update
//               at F_pc straight to the prediction outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_buffer_2bc #(
  parameter int PC_W  = 5,
  parameter int DEPTH = 8,
  parameter int CTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] F_pc,
  input  logic            EX_brn,
  input  logic [PC_W-1:0] EX_pc,
  input  logic [PC_W-1:0] EX_alu_out,
  input  logic            EX_true_taken,
  input  logic            flush,
  output logic            F_BP_hit,
  output logic            F_BP_taken,
  output logic [PC_W-1:0] F_BP_target_pc
);

  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Counter encodings: weakly taken is the smallest value with the MSB set,
  // weakly not-taken is the value just below it.
  localparam logic [CTR_W-1:0] c_CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] c_CTR_WNT = c_CTR_WT - CTR_W'(1);
  localparam logic [CTR_W-1:0] c_CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] c_CTR_MIN = '0;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic               r_valid [DEPTH];
  logic [PC_W-1:0]    r_tag   [DEPTH];
  logic [PC_W-1:0]    r_tgt   [DEPTH];
  logic [CTR_W-1:0]   r_ctr   [DEPTH];
  logic [c_IDX_W-1:0] r_rr_ptr;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic               w_f_hit;
  logic [c_IDX_W-1:0] w_f_idx;
  logic               w_ex_hit;
  logic [c_IDX_W-1:0] w_ex_idx;
  logic               w_any_inv;
  logic [c_IDX_W-1:0] w_inv_idx;
  logic [c_IDX_W-1:0] w_victim;
  logic [CTR_W-1:0]   w_ex_ctr;
  logic [CTR_W-1:0]   w_ctr_upd;
  logic [CTR_W-1:0]   w_new_ctr;
  logic               w_upd;
  logic [PC_W-1:0]    w_f_seq;
  logic               w_reg_taken;
  logic [PC_W-1:0]    w_reg_target;

  // Fetch-side match: scanning from the top down leaves the lowest match.
  always_comb begin
    w_f_hit = 1'b0;
    w_f_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == F_pc)) begin
        w_f_hit = 1'b1;
        w_f_idx = c_IDX_W'(i);
      end
    end
  end

  // EX-side match, used to decide between in-place update and allocation.
  always_comb begin
    w_ex_hit = 1'b0;
    w_ex_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == EX_pc)) begin
        w_ex_hit = 1'b1;
        w_ex_idx = c_IDX_W'(i);
      end
    end
  end

  // Lowest free slot; the round-robin pointer is only used when none exists.
  always_comb begin
    w_any_inv = 1'b0;
    w_inv_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_any_inv = 1'b1;
        w_inv_idx = c_IDX_W'(i);
      end
    end
  end

  assign w_victim = w_any_inv ? w_inv_idx : r_rr_ptr;
  assign w_upd    = EX_brn && !flush;

  // Next counter value for the EX branch: saturating step on a hit,
  // weak initial state on an allocation.
  always_comb begin
    w_ex_ctr = r_ctr[w_ex_idx];
    if (EX_true_taken) begin
      w_ctr_upd = (w_ex_ctr == c_CTR_MAX) ? c_CTR_MAX : (w_ex_ctr + CTR_W'(1));
    end else begin
      w_ctr_upd = (w_ex_ctr == c_CTR_MIN) ? c_CTR_MIN : (w_ex_ctr - CTR_W'(1));
    end
    if (w_ex_hit) begin
      w_new_ctr = w_ctr_upd;
    end else begin
      w_new_ctr = EX_true_taken ? c_CTR_WT : c_CTR_WNT;
    end
  end

  // Prediction from registered state only; sequential PC wraps naturally.
  assign w_f_seq      = F_pc + PC_W'(1);
  assign w_reg_taken  = w_f_hit && r_ctr[w_f_idx][CTR_W-1];
  assign w_reg_target = w_reg_taken ? r_tgt[w_f_idx] : w_f_seq;

`ifdef BTB_BYPASS_EN
  logic w_byp;
  logic w_byp_taken;

  assign w_byp       = w_upd && (EX_pc == F_pc);
  assign w_byp_taken = w_new_ctr[CTR_W-1];

  // Forward the post-update view of the entry being written this cycle.
  always_comb begin
    if (w_byp) begin
      F_BP_hit       = 1'b1;
      F_BP_taken     = w_byp_taken;
      F_BP_target_pc = w_byp_taken ? EX_alu_out : w_f_seq;
    end else begin
      F_BP_hit       = w_f_hit;
      F_BP_taken     = w_reg_taken;
      F_BP_target_pc = w_reg_target;
    end
  end
`else
  assign F_BP_hit       = w_f_hit;
  assign F_BP_taken     = w_reg_taken;
  assign F_BP_target_pc = w_reg_target;
`endif

  // Entry state: async reset, flush invalidates, EX update or allocation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_ctr[i]   <= c_CTR_WNT;
      end
      r_rr_ptr <= '0;
    end else if (flush) begin
      // Flush drops any same-cycle update; payload fields are kept.
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
      r_rr_ptr <= '0;
    end else if (EX_brn) begin
      if (w_ex_hit) begin
        r_ctr[w_ex_idx] <= w_new_ctr;
        if (EX_true_taken) begin
          r_tgt[w_ex_idx] <= EX_alu_out;
        end
      end else begin
        r_valid[w_victim] <= 1'b1;
        r_tag[w_victim]   <= EX_pc;
        r_tgt[w_victim]   <= EX_alu_out;
        r_ctr[w_victim]   <= w_new_ctr;
        // Only evicting a live entry moves the replacement pointer.
        if (!w_any_inv) begin
          r_rr_ptr <= r_rr_ptr + c_IDX_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/branch_target_buffer_2bc.md
Name: branch_target_buffer_2bc

Overview:
- Parametrised successor to the 5-bit, 8-entry single-bit branch buffer in the IF/EX path.
- Fully associative BTB with a valid bit, tag, target and CTR_W-bit saturating direction counter per entry.
- Fetch prediction is combinational; EX-resolved branches update the buffer on the clock edge.
- Adds round-robin replacement that prefers invalid entries, and a pipeline flush that invalidates all entries.

Parameters:
- PC_W, 5, PC/tag/target width in bits.
- DEPTH, 8, number of entries; must be a power of two and ≥2.
- CTR_W, 2, direction counter width; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- F_pc  in  PC_W  fetch PC to look up.
- EX_brn  in  1  instruction in EX is a branch; this is the update strobe.
- EX_pc  in  PC_W  PC of the branch in EX.
- EX_alu_out  in  PC_W  resolved target of the branch in EX.
- EX_true_taken  in  1  resolved direction.
- flush  in  1  synchronous invalidate-all.
- F_BP_hit  out  1  a valid entry matches F_pc.
- F_BP_taken  out  1  predicted taken; 0 on a miss.
- F_BP_target_pc  out  PC_W  predicted next PC.

Behaviour:
- Reset (rst=0, asynchronous):
  - all valid=0, all counters=2^(CTR_W-1)-1 (weakly not-taken), tags/targets=0, rr_ptr=0.
  - Outputs follow combinationally: F_BP_hit=0, F_BP_taken=0, F_BP_target_pc=F_pc+1.
- Lookup (combinational):
  - hit requires valid[i] && tag[i]==F_pc; the lowest matching index wins.
  - taken = hit && counter MSB set.
  - target = taken ? target[i] : F_pc+1, computed modulo 2^PC_W (PC 2^PC_W-1 wraps to 0).
- Update, when EX_brn=1 and flush=0, at posedge clk:
  - EX hit (lowest matching valid index j):
    - counter[j] saturating +1 if taken, -1 if not; it saturates at 2^CTR_W-1 and at 0.
    - if taken, target[j] <= EX_alu_out; the tag is unchanged.
  - EX miss, allocate:
    - victim = lowest invalid index if any; otherwise victim = rr_ptr, and rr_ptr <= (rr_ptr+1) mod DEPTH.
    - rr_ptr advances only on an eviction of a valid entry.
    - victim: valid=1, tag=EX_pc, target=EX_alu_out, counter = taken ? 2^(CTR_W-1) : 2^(CTR_W-1)-1.
- flush=1 at posedge:
  - all valid <= 0 and rr_ptr <= 0; counters, tags and targets are left as-is.
  - flush wins over a same-cycle EX_brn, so that update is dropped.
- Simultaneous fetch and update of the same PC: the lookup sees pre-edge state unless BTB_BYPASS_EN is defined.
- Latency:
  - an update is visible to lookup in the cycle after the edge;
  - a newly allocated entry hits at F_pc one cycle later.
- EX_brn=0: no state change.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Optional Feature:
- BTB_BYPASS_EN defined: when EX_brn=1, flush=0 and EX_pc==F_pc, the outputs reflect the post-update entry in the same cycle:
  - F_BP_hit=1;
  - F_BP_taken = MSB of the new counter value (for an allocation, the initial counter value);
  - F_BP_target_pc = EX_alu_out if the bypassed prediction is taken, else F_pc+1.
- Not defined: there is no forwarding; the lookup uses only registered state, and the extra comparator and mux are absent.

Test Plan:
- Reset, then F_pc=3 -> F_BP_hit=0, F_BP_taken=0, F_BP_target_pc=4; F_pc=31 -> target 0 (wrap).
- Hysteresis (CTR_W=2):
  - EX_brn with EX_pc=3, EX_alu_out=20, taken=1 -> next cycle F_pc=3 gives hit=1, taken=1, target=20.
  - One not-taken update at pc 3 -> hit=1, taken=0, target=4.
  - Then a taken update with EX_alu_out=25 -> taken=1, target=25.
- Saturation:
  - 4 taken updates at pc 7 (alloc at 2, then 3, 3, 3) followed by one not-taken -> counter 2, still taken=1.
  - A second not-taken -> taken=0.
- Replacement (DEPTH=8):
  - Allocate pcs 0–7, then allocate pc 8 -> entry 0 evicted (F_pc=0 misses), rr_ptr=1.
  - Allocate pc 9 -> entry 1 evicted.
  - Pc 2 still hits.
- Flush and reset:
  - flush=1 with a same-cycle EX_brn for pc 5 -> all lookups miss and pc 5 is not allocated.
  - Async rst=0 asserted mid-cycle between edges -> hit=0 immediately.
- Bypass:
  - With BTB_BYPASS_EN, F_pc=EX_pc=10, EX_alu_out=2, taken=1, on a miss -> same cycle hit=1, taken=1, target=2.
  - Without it -> same cycle hit=0, target=11.
